div_sel_ctrl: RTL and testbench
===============================

Name: div_sel_ctrl

Overview:
- Control stage directly upstream of the odd/even clock divider. Drives the divider's `div_sel` and its active-low counter reset.
- Accepts divide-factor change requests over a valid/ready handshake and applies each one through a fixed sequence:
  - gate: output clock held low,
  - load: restart the divider counter,
  - settle: wait before signalling completion.
- Prevents truncated or runt pulses on the divided clock when the ratio changes on the fly.

Parameters:
- MAX_DIV_FAC, 3: max divide factor. Same meaning and constraint (>2) as the divider.
- DEFAULT_SEL, 1: `div_sel` value after reset. Must be ≤ MAX_DIV_FAC.
- GATE_CYC, 2: cycles `div_sel` is forced to 0 before loading a new value. Must be ≥1.
- SEL_W (localparam) = $clog2(MAX_DIV_FAC): matches the divider's `div_sel` width.
- SETTLE_CYC (localparam) = 2*MAX_DIV_FAC.

Ports:
- clk_in      input   1      single clock; same clock that feeds the divider.
- rst         input   1      asynchronous, active-high reset.
- req_valid   input   1      change request valid.
- req_sel     input   SEL_W  requested divide factor.
- req_ready   output  1      high when a request can be accepted (IDLE only).
- div_sel     output  SEL_W  to the divider's `div_sel`.
- div_rst_n   output  1      to the divider's `rst_n`; low pulse restarts its counter.
- cur_sel     output  SEL_W  last committed divide factor; never shows the gating 0.
- busy        output  1      high in GATE, LOAD, SETTLE.
- done        output  1      one-cycle pulse when a change completes.
- err         output  1      one-cycle pulse when a request is rejected.

Behaviour:
- All outputs are registered.
- Reset values, held while rst=1:
  - state = IDLE
  - div_sel = cur_sel = DEFAULT_SEL
  - div_rst_n = 0
  - busy = done = err = 0
  - req_ready = 0
- First clk_in edge after rst deasserts: div_rst_n=1, req_ready=1.
- Handshake is accepted at the edge where req_valid & req_ready.
- IDLE, on accept:
  - req_sel > MAX_DIV_FAC: err=1 next cycle; state and all selects unchanged; remain IDLE.
  - req_sel == cur_sel: done=1 next cycle; no gating; remain IDLE.
  - otherwise: latch req_sel into pend_sel; next state GATE; req_ready=0; busy=1.
- GATE:
  - div_sel=0 (divider output held low) for exactly GATE_CYC cycles, tracked by a down-counter.
  - Then go to LOAD.
- LOAD, exactly one cycle:
  - div_sel=pend_sel, div_rst_n=0, cur_sel=pend_sel.
  - Next state SETTLE.
- SETTLE:
  - div_sel=pend_sel, div_rst_n=1, for SETTLE_CYC cycles.
  - Then IDLE with done=1, busy=0, req_ready=1, all in the same cycle.
- Latency: if accept is at edge E0, done is high in cycle E0+GATE_CYC+2+SETTLE_CYC. With defaults that is cycle 10.
- req_sel=0 is a legal request: the divider output stays low after LOAD.
- req_sel=1 is a legal request (bypass): gating and settle still apply.
- req_valid outside IDLE: ignored, not queued, no err. The requester must hold req_valid until req_ready.
- A back-to-back request valid in the done cycle is accepted at that edge. done and the new GATE entry are then adjacent.
- Reset mid-operation (any state): immediate return to the reset values above; pend_sel is discarded; cur_sel=DEFAULT_SEL.
- done and err are never high in the same cycle.
- busy and req_ready are mutually exclusive after reset release.
- The down-counter is wide enough for max(GATE_CYC, SETTLE_CYC). It is reloaded on every state entry, so no wrap-around is possible.

Test Plan:
- Reset release with defaults → div_sel=1, cur_sel=1, div_rst_n rises on the first edge, req_ready=1, busy=0.
- Request 2 from 1:
  - div_sel=0 in cycles 1–2;
  - cycle 3: div_sel=2, div_rst_n=0, cur_sel=2;
  - cycles 4–9: div_sel=2, busy=1;
  - cycle 10: done=1, req_ready=1.
- Request 3 with MAX_DIV_FAC=3, then request 3 again:
  - first request completes normally;
  - second request gives done next cycle with no div_sel=0 cycle.
- Out-of-range request (MAX_DIV_FAC=5, req_sel=7) → err=1 for one cycle, div_sel/cur_sel unchanged, busy stays 0.
- req_valid asserted during SETTLE with req_sel=0 → ignored until the done cycle, then accepted; sequence ends with div_sel=0, cur_sel=0.
- rst pulsed during GATE of a 1→3 change → immediately div_sel=1, cur_sel=1, div_rst_n=0, busy=0; no done pulse ever.

Source files
------------

// File: rtl/div_sel_ctrl.sv
// Divide-factor change sequencer placed in front of the odd/even clock divider.
// Every ratio change is applied as gate -> load -> settle, so the divided clock never emits a runt pulse.
module div_sel_ctrl #(
    parameter  int MAX_DIV_FAC = 3,
    parameter  int DEFAULT_SEL = 1,
    parameter  int GATE_CYC    = 2,
    localparam int SEL_W       = $clog2(MAX_DIV_FAC)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic [SEL_W-1:0] div_sel,
    output logic             div_rst_n,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int SETTLE_CYC = 2 * MAX_DIV_FAC;
    localparam int CNT_MAX    = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // Handshake: a request is taken on the clk_in edge where req_valid && req_ready;
    // req_ready is only ever high in IDLE, and a valid seen while busy is dropped, not queued.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   r_pend_sel;
    logic [SEL_W-1:0]   w_pend_sel_nxt;

    logic [SEL_W-1:0]   r_div_sel;
    logic [SEL_W-1:0]   r_cur_sel;
    logic               r_div_rst_n;
    logic               r_req_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [SEL_W-1:0]   w_div_sel_nxt;
    logic [SEL_W-1:0]   w_cur_sel_nxt;
    logic               w_div_rst_n_nxt;
    logic               w_req_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               w_accept;
    logic               w_req_oor;
    logic               w_req_same;

    assign w_accept   = req_valid & r_req_ready;
    assign w_req_oor  = ({1'b0, req_sel} > (SEL_W + 1)'(MAX_DIV_FAC));
    assign w_req_same = (req_sel == r_cur_sel);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend_sel  <= '0;
            r_div_sel   <= SEL_W'(DEFAULT_SEL);
            r_cur_sel   <= SEL_W'(DEFAULT_SEL);
            r_div_rst_n <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_sel  <= w_pend_sel_nxt;
            r_div_sel   <= w_div_sel_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_div_rst_n <= w_div_rst_n_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // The counter is reloaded on every state entry, so it never needs to wrap.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pend_sel_nxt = r_pend_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_req_oor && !w_req_same) begin
                    w_state_nxt    = ST_GATE;
                    w_cnt_nxt      = CNT_W'(GATE_CYC - 1);
                    w_pend_sel_nxt = req_sel;
                end
            end
            ST_GATE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered, so their next values follow the state being entered.
    always_comb begin
        w_div_sel_nxt   = r_cur_sel;
        w_cur_sel_nxt   = r_cur_sel;
        w_div_rst_n_nxt = 1'b1;
        w_req_ready_nxt = 1'b0;
        w_busy_nxt      = 1'b1;
        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt      = 1'b0;
                w_req_ready_nxt = 1'b1;
            end
            ST_GATE: begin
                w_div_sel_nxt = '0;
            end
            ST_LOAD: begin
                w_div_sel_nxt   = w_pend_sel_nxt;
                w_cur_sel_nxt   = w_pend_sel_nxt;
                w_div_rst_n_nxt = 1'b0;
            end
            ST_SETTLE: begin
                w_div_sel_nxt = w_pend_sel_nxt;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
        w_done_nxt = ((r_state == ST_SETTLE) && (w_state_nxt == ST_IDLE)) ||
                     ((r_state == ST_IDLE) && w_accept && !w_req_oor && w_req_same);
        w_err_nxt  = (r_state == ST_IDLE) && w_accept && w_req_oor;
    end

    assign req_ready = r_req_ready;
    assign div_sel   = r_div_sel;
    assign div_rst_n = r_div_rst_n;
    assign cur_sel   = r_cur_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_sel_ctrl.sv
// Bench for div_sel_ctrl: two instances (MAX_DIV_FAC 3 and 5) checked every cycle against a
// timeline model that derives outputs from the cycles elapsed since a request was accepted.
module tb_div_sel_ctrl;

    localparam int G   = 2;
    localparam int DEF = 1;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       vld [2];
    logic [3:0] rsel [2];

    logic [1:0] d0_div_sel, d0_cur_sel, d0_dbg;
    logic       d0_ready, d0_rst_n, d0_busy, d0_done, d0_err;
    logic [2:0] d1_div_sel, d1_cur_sel;
    logic [1:0] d1_dbg;
    logic       d1_ready, d1_rst_n, d1_busy, d1_done, d1_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];

    int m_t    [2];
    int m_cur  [2];
    int m_pend [2];
    bit m_rel  [2];
    bit m_done [2];
    bit m_err  [2];

    always #5 clk_in = ~clk_in;

    div_sel_ctrl #(.MAX_DIV_FAC(3), .DEFAULT_SEL(DEF), .GATE_CYC(G)) u_dut0 (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_valid (vld[0]),
        .req_sel   (rsel[0][1:0]),
        .req_ready (d0_ready),
        .div_sel   (d0_div_sel),
        .div_rst_n (d0_rst_n),
        .cur_sel   (d0_cur_sel),
        .busy      (d0_busy),
        .done      (d0_done),
        .err       (d0_err),
        .dbg_state (d0_dbg)
    );

    div_sel_ctrl #(.MAX_DIV_FAC(5), .DEFAULT_SEL(DEF), .GATE_CYC(G)) u_dut1 (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_valid (vld[1]),
        .req_sel   (rsel[1][2:0]),
        .req_ready (d1_ready),
        .div_sel   (d1_div_sel),
        .div_rst_n (d1_rst_n),
        .cur_sel   (d1_cur_sel),
        .busy      (d1_busy),
        .done      (d1_done),
        .err       (d1_err),
        .dbg_state (d1_dbg)
    );

    function automatic int max_fac(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    function automatic int settle(input int i);
        return 2 * max_fac(i);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%h, expected 0x%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] obs_word(input int i);
        if (i == 0)
            return {5'b0, d0_div_sel, d0_rst_n, 2'b0, d0_cur_sel, d0_busy, d0_ready, d0_done, d0_err};
        return {4'b0, d1_div_sel, d1_rst_n, 1'b0, d1_cur_sel, d1_busy, d1_ready, d1_done, d1_err};
    endfunction

    function automatic logic [15:0] exp_word(input int i);
        int ds;
        bit rn, b, rd;
        if (!m_rel[i])
            return {3'b0, 4'(DEF), 1'b0, 4'(DEF), 4'b0000};
        if (m_t[i] == 0) begin
            ds = m_cur[i]; rn = 1'b1; b = 1'b0; rd = 1'b1;
        end else if (m_t[i] <= G) begin
            ds = 0; rn = 1'b1; b = 1'b1; rd = 1'b0;
        end else if (m_t[i] == G + 1) begin
            ds = m_pend[i]; rn = 1'b0; b = 1'b1; rd = 1'b0;
        end else begin
            ds = m_pend[i]; rn = 1'b1; b = 1'b1; rd = 1'b0;
        end
        return {3'b0, 4'(ds), rn, 4'(m_cur[i]), b, rd, m_done[i], m_err[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_cur[i] = DEF; m_pend[i] = 0;
            m_rel[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    // A change occupies G gate cycles, one load cycle, settle(i) cycles, then the done cycle.
    task automatic model_edge(input int i);
        bit acc;
        if (rst) return;
        acc = m_rel[i] && (m_t[i] == 0) && vld[i];
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (!m_rel[i]) begin
            m_rel[i] = 1'b1;
        end else if (m_t[i] > 0) begin
            m_t[i]++;
            if (m_t[i] == G + 2 + settle(i)) begin
                m_t[i] = 0;
                m_done[i] = 1'b1;
            end
        end else if (acc) begin
            if (int'(rsel[i]) > max_fac(i)) m_err[i] = 1'b1;
            else if (int'(rsel[i]) == m_cur[i]) m_done[i] = 1'b1;
            else begin
                m_pend[i] = int'(rsel[i]);
                m_t[i] = 1;
            end
        end
        if (m_t[i] == G + 1) m_cur[i] = m_pend[i];
    endtask

    task automatic check_all();
        logic [15:0] e;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            check($sformatf("outs_dut%0d", i), obs_word(i), e);
        end
        check("done_err_excl", 16'({d0_done & d0_err, d1_done & d1_err}), 16'(0));
        check("busy_ready_excl", 16'({d0_busy & d0_ready, d1_busy & d1_ready}), 16'(0));
        check("dbg_idle_vs_busy", 16'({d0_dbg == 2'd0, d1_dbg == 2'd0}), 16'({~d0_busy, ~d1_busy}));
    endtask

    task automatic step();
        @(posedge clk_in);
        for (int i = 0; i < 2; i++) begin
            model_edge(i);
            exp_q.push_back(exp_word(i));
        end
        @(negedge clk_in);
        check_all();
    endtask

    task automatic reset_now();
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) exp_q.push_back(exp_word(i));
        check_all();
    endtask

    function automatic bit ready_obs(input int i);
        return (i == 0) ? d0_ready : d1_ready;
    endfunction

    function automatic bit done_obs(input int i);
        return (i == 0) ? d0_done : d1_done;
    endfunction

    task automatic send(input int i, input int s);
        int n;
        n = 0;
        vld[i]  = 1'b1;
        rsel[i] = 4'(s);
        while (!ready_obs(i) && n < 100) begin
            step();
            n++;
        end
        check("send_ready_timeout", 16'(n < 100), 16'(1));
        step();
        vld[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 1;
        while (!done_obs(i) && n < 60) begin
            step();
            n++;
        end
        check("done_timeout", 16'(n < 60), 16'(1));
    endtask

    initial begin
        int n;
        int done_seen;
        vld[0] = 1'b0; vld[1] = 1'b0;
        rsel[0] = 4'd0; rsel[1] = 4'd0;
        model_reset();
        repeat (3) step();
        check("reset_div_sel", 16'(d0_div_sel), 16'(1));
        check("reset_rst_n", 16'(d0_rst_n), 16'(0));
        rst = 1'b0;
        step();
        check("release_rst_n", 16'(d0_rst_n), 16'(1));
        check("release_ready", 16'({d0_ready, d0_busy}), 16'(2'b10));

        // 1 -> 2: done lands ten cycles after the accept edge.
        send(0, 2);
        wait_done(0, n);
        check("latency_1_to_2", 16'(n), 16'(10));
        check("cur_after_2", 16'(d0_cur_sel), 16'(2));

        // 2 -> 3, then 3 again completes at once with no gating.
        send(0, 3);
        wait_done(0, n);
        send(0, 3);
        check("same_sel_done", 16'({d0_done, d0_busy, d0_div_sel}), 16'({1'b1, 1'b0, 2'd3}));

        // Out-of-range on the MAX_DIV_FAC=5 instance.
        send(1, 7);
        check("oor_err", 16'({d1_err, d1_busy, d1_cur_sel, d1_div_sel}), 16'({1'b1, 1'b0, 3'd1, 3'd1}));
        step();
        check("oor_err_one_cycle", 16'(d1_err), 16'(0));

        // Request held through SETTLE is taken only in the done cycle.
        send(0, 1);
        repeat (4) step();
        send(0, 0);
        wait_done(0, n);
        check("sel0_final", 16'({d0_cur_sel, d0_div_sel}), 16'(0));

        // Reset during GATE of 1 -> 3 discards the change.
        send(0, 1);
        wait_done(0, n);
        send(0, 3);
        reset_now();
        check("rst_mid_gate", 16'({d0_div_sel, d0_cur_sel, d0_rst_n, d0_busy}), 16'({2'd1, 2'd1, 1'b0, 1'b0}));
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (d0_done) done_seen++;
        end
        check("no_done_after_rst", 16'(done_seen), 16'(0));

        // Randomized traffic on both instances with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i]  = ($urandom_range(0, 2) != 0);
                rsel[i] = 4'($urandom_range(0, (i == 0) ? 3 : 7));
            end
            if ($urandom_range(0, 299) == 0) reset_now();
            else rst = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
